// File: rtl/instr_encoder.sv
// MIPS instruction encoder: mnemonic + fields in, 32-bit word tagged with a running byte address out through a small FIFO.
// Optional build macro INSTR_ENCODER_NOP_FILL_EN: illegal mnemonics emit a NOP word instead of being dropped.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Clear,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [4:0]                 Mnemonic,
  input  logic [4:0]                 Rs,
  input  logic [4:0]                 Rt,
  input  logic [4:0]                 Rd,
  input  logic [4:0]                 Shamt,
  input  logic [15:0]                Imm,
  input  logic [25:0]                Target,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [31:0]                OutInstr,
  output logic [31:0]                OutAddr,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Mnemonic codes
  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_NOR  = 5'd4;
  localparam logic [4:0] MN_SLL  = 5'd5;
  localparam logic [4:0] MN_SRL  = 5'd6;
  localparam logic [4:0] MN_JR   = 5'd7;
  localparam logic [4:0] MN_ADDI = 5'd8;
  localparam logic [4:0] MN_ORI  = 5'd9;
  localparam logic [4:0] MN_LUI  = 5'd10;
  localparam logic [4:0] MN_LW   = 5'd11;
  localparam logic [4:0] MN_SW   = 5'd12;
  localparam logic [4:0] MN_BEQ  = 5'd13;
  localparam logic [4:0] MN_BNE  = 5'd14;
  localparam logic [4:0] MN_J    = 5'd15;
  localparam logic [4:0] MN_JAL  = 5'd16;

  // Opcodes and R-type function codes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  logic [31:0]   encWord;
  logic          encLegal;
  logic [31:0]   wordIn;
  logic          pushEn;
  logic          wrEn;
  logic          popEn;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] cnt;
  logic [31:0]   runAddr;
  logic          illegalQ;

  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   addrMem  [DEPTH];

  // Combinational encoder; forced-zero fields never look at their inputs.
  always_comb begin
    encWord  = 32'h0;
    encLegal = 1'b1;
    case (Mnemonic)
      MN_ADD:  encWord = {OP_RTYPE, Rs, Rt, Rd, 5'd0, FN_ADD};
      MN_SUB:  encWord = {OP_RTYPE, Rs, Rt, Rd, 5'd0, FN_SUB};
      MN_AND:  encWord = {OP_RTYPE, Rs, Rt, Rd, 5'd0, FN_AND};
      MN_OR:   encWord = {OP_RTYPE, Rs, Rt, Rd, 5'd0, FN_OR};
      MN_NOR:  encWord = {OP_RTYPE, Rs, Rt, Rd, 5'd0, FN_NOR};
      MN_SLL:  encWord = {OP_RTYPE, 5'd0, Rt, Rd, Shamt, FN_SLL};
      MN_SRL:  encWord = {OP_RTYPE, 5'd0, Rt, Rd, Shamt, FN_SRL};
      MN_JR:   encWord = {OP_RTYPE, Rs, 5'd0, 5'd0, 5'd0, FN_JR};
      MN_ADDI: encWord = {OP_ADDI, Rs, Rt, Imm};
      MN_ORI:  encWord = {OP_ORI, Rs, Rt, Imm};
      MN_LUI:  encWord = {OP_LUI, 5'd0, Rt, Imm};
      MN_LW:   encWord = {OP_LW, Rs, Rt, Imm};
      MN_SW:   encWord = {OP_SW, Rs, Rt, Imm};
      MN_BEQ:  encWord = {OP_BEQ, Rs, Rt, Imm};
      MN_BNE:  encWord = {OP_BNE, Rs, Rt, Imm};
      MN_J:    encWord = {OP_J, Target};
      MN_JAL:  encWord = {OP_JAL, Target};
      default: encLegal = 1'b0;
    endcase
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // InReady looks only at occupancy and Clear, never at a same-cycle pop.
  assign InReady  = (cnt < CW'(DEPTH)) && !Clear;
  assign OutValid = (cnt != '0);
  assign pushEn   = InValid && InReady;
  assign popEn    = OutValid && OutReady && !Clear;

`ifdef INSTR_ENCODER_NOP_FILL_EN
  assign wrEn   = pushEn;
  assign wordIn = encLegal ? encWord : 32'h0000_0000;
`else
  assign wrEn   = pushEn && encLegal;
  assign wordIn = encWord;
`endif

  // Storage is not reset; the empty-gating on the outputs hides stale entries.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      instrMem[wrPtr] <= wordIn;
      addrMem[wrPtr]  <= runAddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      runAddr  <= BASE_ADDR;
      illegalQ <= 1'b0;
    end else if (Clear) begin
      cnt      <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      runAddr  <= BASE_ADDR;
      illegalQ <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtr   <= wrPtr + AW'(1);
        runAddr <= runAddr + 32'd4;
      end
      if (popEn) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({wrEn, popEn})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (pushEn && !encLegal) begin
        illegalQ <= 1'b1;
      end
    end
  end

  assign OutInstr = OutValid ? instrMem[rdPtr] : 32'h0;
  assign OutAddr  = OutValid ? addrMem[rdPtr]  : 32'h0;
  assign Count    = cnt;
  assign Illegal  = illegalQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, handshake/backpressure, illegal, Clear and reset corner cases.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef INSTR_ENCODER_NOP_FILL_EN
  localparam bit NOP_FILL = 1'b1;
`else
  localparam bit NOP_FILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Clear = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  Mnemonic = '0;
  logic [4:0]  Rs = '0, Rt = '0, Rd = '0, Shamt = '0;
  logic [15:0] Imm = '0;
  logic [25:0] Target = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] OutInstr;
  logic [31:0] OutAddr;
  logic [2:0]  Count;
  logic        Illegal;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Clear(Clear),
    .InValid(InValid), .InReady(InReady),
    .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
    .Imm(Imm), .Target(Target),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutInstr(OutInstr), .OutAddr(OutAddr),
    .Count(Count), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = BASE;

  typedef struct {
    logic [4:0]  mn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops are decided on the stable half of the cycle, before the rising edge that performs them.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (reset && OutValid && OutReady && !Clear) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h @%h expected none", OutInstr, OutAddr);
      end else begin
        e = exp_q.pop_front();
        check("word_instr", OutInstr, e[63:32]);
        check("word_addr", OutAddr, e[31:0]);
      end
    end
  end

  task automatic do_push(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] exp_instr);
    bit done;
    bit legal;
    done  = 1'b0;
    legal = (mn <= 5'd16);
    @(posedge clk); #1;
    Mnemonic = mn; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = tgt;
    InValid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (InReady) begin
        done = 1'b1;
        if (legal || NOP_FILL) begin
          exp_q.push_back({(legal ? exp_instr : 32'h0), exp_addr});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got InReady=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !OutValid) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    vecs[0]  = '{5'd0,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0022_1820};
    vecs[1]  = '{5'd1,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0022_1822};
    vecs[2]  = '{5'd2,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0022_1824};
    vecs[3]  = '{5'd3,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0022_1825};
    vecs[4]  = '{5'd4,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0022_1827};
    vecs[5]  = '{5'd5,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0002_1900};
    vecs[6]  = '{5'd6,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0002_1902};
    vecs[7]  = '{5'd7,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0020_0008};
    vecs[8]  = '{5'd8,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h2022_1234};
    vecs[9]  = '{5'd9,  5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h3422_1234};
    vecs[10] = '{5'd10, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h3C02_1234};
    vecs[11] = '{5'd11, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h8C22_1234};
    vecs[12] = '{5'd12, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'hAC22_1234};
    vecs[13] = '{5'd13, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h1022_1234};
    vecs[14] = '{5'd14, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h1422_1234};
    vecs[15] = '{5'd15, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h08AB_CDEF};
    vecs[16] = '{5'd16, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, 32'h0CAB_CDEF};
    vecs[17] = '{5'd0,  5'd8, 5'd9, 5'd10, 5'd0, 16'h0000, 26'h0, 32'h0109_5020};
    vecs[18] = '{5'd5,  5'd7, 5'd9, 5'd8,  5'd2, 16'h0000, 26'h0, 32'h0009_4080};
    vecs[19] = '{5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA8_0004};

    // Reset state
    #12;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_illegal", 32'(Illegal), 32'd0);
    check("rst_outinstr", OutInstr, 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_inready", 32'(InReady), 32'd1);

    // Single ADDI, one-cycle latency to OutValid
    OutReady = 1'b1;
    do_push(5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 32'h2008_0005);
    check("lat_outvalid", 32'(OutValid), 32'd1);
    check("lat_instr", OutInstr, 32'h2008_0005);
    check("lat_addr", OutAddr, BASE);
    drain();

    // Encoding table
    for (int i = 0; i < 20; i++) begin
      do_push(vecs[i].mn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
              vecs[i].imm, vecs[i].tgt, vecs[i].instr);
    end
    drain();
    check("table_illegal", 32'(Illegal), 32'd0);

    // Backpressure: fill, then pop-only at full, then push+pop at three
    OutReady = 1'b0;
    for (int i = 0; i < 4; i++) do_push(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 32'h8FA8_0004);
    check("full_count", 32'(Count), 32'd4);
    check("full_inready", 32'(InReady), 32'd0);
    check("full_head", OutInstr, 32'h8FA8_0004);
    @(posedge clk); #1;
    Mnemonic = 5'd11; Rs = 5'd29; Rt = 5'd8; Imm = 16'd4;
    InValid = 1'b1; OutReady = 1'b1;
    @(negedge clk);
    check("full_pop_inready", 32'(InReady), 32'd0);
    @(posedge clk); #1;
    check("full_pop_count", 32'(Count), 32'd3);
    @(negedge clk);
    check("pushpop_inready", 32'(InReady), 32'd1);
    if (InReady) begin
      exp_q.push_back({32'h8FA8_0004, exp_addr});
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    check("pushpop_count", 32'(Count), 32'd3);
    drain();

    // Illegal mnemonic followed by J
    do_push(5'd20, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 32'h0);
    check("illegal_flag", 32'(Illegal), 32'd1);
    do_push(5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h0810_0000);
    drain();

    // Clear with queued words and a concurrent request
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) do_push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1820);
    check("clr_pre_count", 32'(Count), 32'd3);
    @(posedge clk); #1;
    Clear = 1'b1; InValid = 1'b1; Mnemonic = 5'd0;
    @(negedge clk);
    check("clr_inready", 32'(InReady), 32'd0);
    @(posedge clk); #1;
    Clear = 1'b0; InValid = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
    check("clr_count", 32'(Count), 32'd0);
    check("clr_outvalid", 32'(OutValid), 32'd0);
    check("clr_illegal", 32'(Illegal), 32'd0);
    OutReady = 1'b1;
    do_push(5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 32'h2008_0005);
    drain();

    // Reset mid-stream
    OutReady = 1'b0;
    for (int i = 0; i < 2; i++) do_push(5'd9, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'h0, 32'h3464_00FF);
    check("mid_pre_count", 32'(Count), 32'd2);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("mid_count", 32'(Count), 32'd0);
    check("mid_outvalid", 32'(OutValid), 32'd0);
    check("mid_outinstr", OutInstr, 32'h0);
    exp_q.delete();
    exp_addr = BASE;
    @(negedge clk); reset = 1'b1;
    OutReady = 1'b1;
    do_push(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 32'h0FFF_FFFF);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
